seg_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the board I/O layer of the MIPS system. It replaces fixed 4-digit scanning with a configurable digit count, per-digit blanking and decimal point, 16-level brightness PWM, leading-zero suppression, and tear-free double-buffered updates committed at frame boundaries. The CPU-side I/O register writes `load` plus data; the block drives `ds` (digit select) and `seg` (segments) pins.

---
 rtl/seg_scan_mux.sv | 151 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver with per-digit blanking,
// decimal points, 16-level PWM brightness, leading-zero suppression and
// double-buffered updates that take effect only at frame boundaries.
module seg_scan_mux #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int ACTIVE_LOW_SEG = 1,
   parameter int ACTIVE_LOW_SEL = 1
) (
   input  logic                  clk_50MHz,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [3:0]            bright,
   input  logic                  lzs,
   output logic [DIGITS-1:0]     ds,
   output logic [7:0]            seg,
   output logic                  frame_done
);

   localparam int STEP_N = SCAN_DIV / 16;
   localparam int STEP_W = (STEP_N > 1) ? $clog2(STEP_N) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_N - 1);
   localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{ACTIVE_LOW_SEL != 0}};

   logic [STEP_W-1:0]   step;
   logic [3:0]          phase;
   logic [IDX_W-1:0]    idx;
   logic                step_tc, slot_end, frame_wrap;

   // pending (CPU-written) and active (displayed) register sets
   logic [4*DIGITS-1:0] pnd_value, act_value;
   logic [DIGITS-1:0]   pnd_dp, act_dp, pnd_blank, act_blank;
   logic [3:0]          pnd_bright, act_bright;
   logic                pnd_lzs, act_lzs, pend_v;

   logic [DIGITS-1:0]   supp;
   logic                zero_above;
   logic                lit;
   logic [3:0]          nib;
   logic                wrap_d;

   // hex font, gfedcba
   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
         4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
         4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
         4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
      endcase
   endfunction

   assign step_tc    = (step == STEP_MAX);
   assign slot_end   = step_tc && (phase == 4'hF);
   assign frame_wrap = slot_end && (idx == IDX_MAX);

   // prescaler, PWM phase and digit index
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         step  <= '0;
         phase <= '0;
         idx   <= '0;
      end else begin
         step <= step_tc ? '0 : step + 1'b1;
         if (step_tc) phase <= phase + 1'b1;
         if (slot_end) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
   end

   // pending buffer: last load wins; flag cleared whenever a frame commits
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         pnd_value  <= '0;
         pnd_dp     <= '0;
         pnd_blank  <= '1;
         pnd_bright <= '0;
         pnd_lzs    <= 1'b0;
         pend_v     <= 1'b0;
      end else begin
         if (load) begin
            pnd_value  <= value;
            pnd_dp     <= dp;
            pnd_blank  <= blank;
            pnd_bright <= bright;
            pnd_lzs    <= lzs;
         end
         if (frame_wrap)  pend_v <= 1'b0;
         else if (load)   pend_v <= 1'b1;
      end
   end

   // active set: updated only at frame wrap; a load on that very cycle bypasses pending
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         act_value  <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         act_bright <= '0;
         act_lzs    <= 1'b0;
      end else if (frame_wrap && load) begin
         act_value  <= value;
         act_dp     <= dp;
         act_blank  <= blank;
         act_bright <= bright;
         act_lzs    <= lzs;
      end else if (frame_wrap && pend_v) begin
         act_value  <= pnd_value;
         act_dp     <= pnd_dp;
         act_blank  <= pnd_blank;
         act_bright <= pnd_bright;
         act_lzs    <= pnd_lzs;
      end
   end

   // leading-zero suppression: digit i>=1 dark when it and all higher nibbles are zero
   always_comb begin
      supp       = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (act_value[4*i +: 4] == 4'h0);
         supp[i]    = act_lzs && zero_above;
      end
   end

   // current digit lit decision; phase 15 never passes the brightness compare
   always_comb begin
      nib = act_value[4*idx +: 4];
      lit = !act_blank[idx] && !supp[idx] && (phase < act_bright);
   end

   // registered pins; frame_done delayed to line up with digit 0's first output
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         ds         <= SEL_OFF;
         seg        <= SEG_OFF;
         wrap_d     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ds         <= lit ? ((DIGITS'(1) << idx) ^ SEL_OFF) : SEL_OFF;
         seg        <= lit ? ({act_dp[idx], font(nib)} ^ SEG_OFF) : SEG_OFF;
         wrap_d     <= frame_wrap;
         frame_done <= wrap_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (DIGITS=4, SCAN_DIV=32, active-low pins).
module tb_seg_scan_mux;

   logic        clk_50MHz = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0, blank = '0, bright = '0;
   logic        lzs = 1'b0;
   logic [3:0]  ds;
   logic [7:0]  seg;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   seg_scan_mux #(.DIGITS(4), .SCAN_DIV(32), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_SEL(1)) dut (
      .clk_50MHz(clk_50MHz), .rst(rst), .load(load), .value(value), .dp(dp),
      .blank(blank), .bright(bright), .lzs(lzs), .ds(ds), .seg(seg), .frame_done(frame_done)
   );

   always #5 clk_50MHz = ~clk_50MHz;

   typedef struct {
      logic [15:0]      value;
      logic [3:0]       dp;
      logic [3:0]       blank;
      logic [3:0]       bright;
      logic             lzs;
      logic [3:0][7:0]  segs;   // expected pin pattern per digit (when lit)
      logic [3:0]       on;     // digits expected to light at all
   } vec_t;

   vec_t tv[9];

   task automatic apply(input int v);
      value  = tv[v].value;
      dp     = tv[v].dp;
      blank  = tv[v].blank;
      bright = tv[v].bright;
      lzs    = tv[v].lzs;
      load   = 1'b1;
   endtask

   // check nk cycles of a frame against vector ev, starting at the frame_done sample;
   // optionally pulse load with vectors v1/v2 at cycles l1/l2
   task automatic run_frame(input int ev, input int l1, input int v1,
                            input int l2, input int v2, input int nk);
      int d, ph;
      logic lit, efd;
      logic [3:0] sel, eds;
      logic [7:0] eseg;
      for (int k = 0; k < nk; k++) begin
         d    = k / 32;
         ph   = (k % 32) / 2;
         lit  = tv[ev].on[d] && (ph < int'(tv[ev].bright));
         sel  = 4'b0001 << d;
         eds  = lit ? ~sel : 4'hF;
         eseg = lit ? tv[ev].segs[d] : 8'hFF;
         efd  = (k == 0);
         checks++;
         if (ds !== eds || seg !== eseg || frame_done !== efd) begin
            errors++;
            $display("FAIL frame v%0d k=%0d: ds=%h seg=%h fd=%b, want ds=%h seg=%h fd=%b",
                     ev, k, ds, seg, frame_done, eds, eseg, efd);
         end
         load = 1'b0;
         if (k == l1) apply(v1);
         else if (k == l2) apply(v2);
         @(negedge clk_50MHz);
      end
      load = 1'b0;
   endtask

   task automatic wait_fd();
      int n = 0;
      while (frame_done !== 1'b1 && n < 300) begin
         @(negedge clk_50MHz);
         n++;
      end
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL wait_frame_done: fd=%b after %0d cycles, want 1", frame_done, n);
      end
   endtask

   task automatic check_dark(input string name);
      checks++;
      if (ds !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s: ds=%h seg=%h fd=%b, want ds=f seg=ff fd=0", name, ds, seg, frame_done);
      end
   endtask

   initial begin
      int seq[6];
      int prev;
      //          value     dp       blank    br     lzs   segs {d3,d2,d1,d0}                 on
      tv[0] = '{16'h12F0, 4'b0000, 4'b0000, 4'd15, 1'b0, {8'hF9, 8'hA4, 8'h8E, 8'hC0}, 4'b1111};
      tv[1] = '{16'h12F0, 4'b0000, 4'b0000, 4'd4,  1'b0, {8'hF9, 8'hA4, 8'h8E, 8'hC0}, 4'b1111};
      tv[2] = '{16'h12F0, 4'b0000, 4'b0000, 4'd0,  1'b0, {8'hF9, 8'hA4, 8'h8E, 8'hC0}, 4'b0000};
      tv[3] = '{16'h0050, 4'b1000, 4'b0000, 4'd15, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4'b0011};
      tv[4] = '{16'h0000, 4'b0000, 4'b0000, 4'd15, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001};
      tv[5] = '{16'h1111, 4'b0000, 4'b0000, 4'd15, 1'b0, {8'hF9, 8'hF9, 8'hF9, 8'hF9}, 4'b1111};
      tv[6] = '{16'h2222, 4'b0000, 4'b0000, 4'd15, 1'b0, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b1111};
      tv[7] = '{16'h89AB, 4'b0101, 4'b0010, 4'd8,  1'b0, {8'h80, 8'h10, 8'hFF, 8'h03}, 4'b1101};
      tv[8] = '{16'h0000, 4'b0000, 4'b1111, 4'd0,  1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000};

      // reset state, then a full frame dark with no frame_done
      repeat (3) begin
         @(negedge clk_50MHz);
         check_dark("in_reset");
      end
      rst = 1'b0;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk_50MHz);
         check_dark("after_reset");
      end
      wait_fd();

      // table: load mid-frame, current frame unchanged, next frame shows it
      seq  = '{0, 1, 2, 3, 4, 7};
      prev = 8;
      for (int i = 0; i < 6; i++) begin
         run_frame(prev, 5, seq[i], -1, 0, 128);
         run_frame(seq[i], -1, 0, -1, 0, 128);
         prev = seq[i];
      end

      // two loads in one frame: last one wins, no tearing
      run_frame(7, 10, 5, 40, 6, 128);
      run_frame(6, -1, 0, -1, 0, 128);

      // load sampled on the frame-wrap edge goes straight to the next frame
      run_frame(6, 126, 0, -1, 0, 128);
      run_frame(0, -1, 0, -1, 0, 128);
      run_frame(0, -1, 0, -1, 0, 128);

      // reset mid-frame with a pending load: dark immediately, pending discarded
      run_frame(0, 20, 5, -1, 0, 60);
      rst = 1'b1;
      #1;
      check_dark("rst_async");
      repeat (2) begin
         @(negedge clk_50MHz);
         check_dark("rst_hold");
      end
      rst = 1'b0;
      wait_fd();
      run_frame(8, -1, 0, -1, 0, 128);
      run_frame(8, -1, 0, -1, 0, 128);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
